// File: rtl/nld_drive_ramp_sequencer_if.sv
// AXI4-Lite write-only channel bundle used by the
// drive ramp sequencer to program the NLD registers.
interface nld_drive_ramp_sequencer_if;
   logic [3:0]  awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output awaddr, awvalid, wdata, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/nld_drive_ramp_sequencer.sv
// Ramps the NLD drive register one step per frame tick and
// orders the enable write so switching happens at low drive.
module nld_drive_ramp_sequencer #(
   parameter int unsigned TICKS_PER_STEP = 1,
   parameter logic [3:0]  ADDR_CTRL      = 4'h0,
   parameter logic [3:0]  ADDR_DRIVE     = 4'h4,
   parameter logic [15:0] DRIVE_RESET    = 16'd16384
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_drive,
   input  logic        cmd_enable,
   input  logic [15:0] cmd_step,
   input  logic        frame_tick,
   nld_drive_ramp_sequencer_if.master m_axi,
   output logic [15:0] cur_drive,
   output logic        cur_enable,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE, EN_WR, EN_RESP, WAIT_TICK,
      DRV_WR, DRV_RESP, DIS_WR, DIS_RESP
   } state_t;

   localparam logic [7:0] TPS = 8'(TICKS_PER_STEP);

   state_t      state_q, state_d;
   logic [7:0]  tick_cnt_q, tick_cnt_d;
   logic        tick_pend_q, tick_pend_d;
   logic [15:0] tgt_drive_q, tgt_drive_d;
   logic        tgt_en_q, tgt_en_d;
   logic [15:0] step_q, step_d;
   logic [15:0] next_q, next_d;
   logic [15:0] cur_drive_q, cur_drive_d;
   logic        cur_enable_q, cur_enable_d;
   logic        err_q, err_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

   logic        is_wr;
   logic        aw_ok;
   logic        w_ok;
   logic        resp_ok;
   logic        tick_in;
   logic [16:0] up_sum;
   logic [15:0] dn_gap;
   logic [15:0] nxt_drive;
   state_t      after_ramp;

   // Next ramp value: step toward target, clamped, never wrapping
   always_comb begin
      up_sum    = {1'b0, cur_drive_q} + {1'b0, step_q};
      dn_gap    = cur_drive_q - tgt_drive_q;
      nxt_drive = tgt_drive_q;
      if (step_q == 16'd0) begin
         nxt_drive = tgt_drive_q;
      end else if (tgt_drive_q > cur_drive_q) begin
         if (up_sum < {1'b0, tgt_drive_q})
            nxt_drive = up_sum[15:0];
      end else begin
         if (step_q < dn_gap)
            nxt_drive = cur_drive_q - step_q;
      end
   end

   // AXI write channel outputs follow the current write state
   always_comb begin
      is_wr = (state_q == EN_WR) || (state_q == DRV_WR) ||
              (state_q == DIS_WR);
      m_axi.awvalid = is_wr && !aw_done_q;
      m_axi.wvalid  = is_wr && !w_done_q;
      m_axi.bready  = (state_q == EN_RESP) ||
                      (state_q == DRV_RESP) ||
                      (state_q == DIS_RESP);
      m_axi.awaddr  = 4'h0;
      m_axi.wdata   = 32'd0;
      unique case (state_q)
         EN_WR: begin
            m_axi.awaddr = ADDR_CTRL;
            m_axi.wdata  = 32'd1;
         end
         DRV_WR: begin
            m_axi.awaddr = ADDR_DRIVE;
            m_axi.wdata  = {16'd0, next_q};
         end
         DIS_WR: begin
            m_axi.awaddr = ADDR_CTRL;
            m_axi.wdata  = 32'd0;
         end
         default: begin
            m_axi.awaddr = 4'h0;
            m_axi.wdata  = 32'd0;
         end
      endcase
   end

   // Sequencer next-state and datapath updates
   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      tick_pend_d  = tick_pend_q;
      tgt_drive_d  = tgt_drive_q;
      tgt_en_d     = tgt_en_q;
      step_d       = step_q;
      next_d       = next_q;
      cur_drive_d  = cur_drive_q;
      cur_enable_d = cur_enable_q;
      err_d        = err_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;

      aw_ok   = aw_done_q || (m_axi.awvalid && m_axi.awready);
      w_ok    = w_done_q  || (m_axi.wvalid  && m_axi.wready);
      resp_ok = (m_axi.bresp == 2'b00);
      tick_in = frame_tick || tick_pend_q;

      after_ramp = (!tgt_en_q && cur_enable_q) ? DIS_WR : IDLE;

      if (frame_tick &&
          ((state_q == DRV_WR) || (state_q == DRV_RESP)))
         tick_pend_d = 1'b1;

      if (is_wr) begin
         aw_done_d = aw_ok;
         w_done_d  = w_ok;
      end

      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               tgt_drive_d = cmd_drive;
               tgt_en_d    = cmd_enable;
               step_d      = cmd_step;
               tick_cnt_d  = 8'd0;
               tick_pend_d = 1'b0;
               if (cmd_enable && !cur_enable_q)
                  state_d = EN_WR;
               else if (cmd_drive != cur_drive_q)
                  state_d = WAIT_TICK;
               else if (!cmd_enable && cur_enable_q)
                  state_d = DIS_WR;
            end
         end
         EN_WR: begin
            if (aw_ok && w_ok) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = EN_RESP;
            end
         end
         EN_RESP: begin
            if (m_axi.bvalid) begin
               if (resp_ok) begin
                  cur_enable_d = 1'b1;
                  state_d = (tgt_drive_q != cur_drive_q) ?
                            WAIT_TICK : IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_TICK: begin
            if (tick_in) begin
               tick_pend_d = tick_pend_q && frame_tick;
               if (tick_cnt_q + 8'd1 >= TPS) begin
                  tick_cnt_d = 8'd0;
                  next_d     = nxt_drive;
                  state_d    = DRV_WR;
               end else begin
                  tick_cnt_d = tick_cnt_q + 8'd1;
               end
            end
         end
         DRV_WR: begin
            if (aw_ok && w_ok) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = DRV_RESP;
            end
         end
         DRV_RESP: begin
            if (m_axi.bvalid) begin
               if (resp_ok) begin
                  cur_drive_d = next_q;
                  if (next_q == tgt_drive_q) begin
                     tick_pend_d = 1'b0;
                     state_d     = after_ramp;
                  end else begin
                     state_d = WAIT_TICK;
                  end
               end else begin
                  err_d       = 1'b1;
                  tick_pend_d = 1'b0;
                  state_d     = IDLE;
               end
            end
         end
         DIS_WR: begin
            if (aw_ok && w_ok) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = DIS_RESP;
            end
         end
         DIS_RESP: begin
            if (m_axi.bvalid) begin
               if (resp_ok)
                  cur_enable_d = 1'b0;
               else
                  err_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         tick_cnt_q   <= 8'd0;
         tick_pend_q  <= 1'b0;
         tgt_drive_q  <= DRIVE_RESET;
         tgt_en_q     <= 1'b0;
         step_q       <= 16'd0;
         next_q       <= DRIVE_RESET;
         cur_drive_q  <= DRIVE_RESET;
         cur_enable_q <= 1'b0;
         err_q        <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         tick_pend_q  <= tick_pend_d;
         tgt_drive_q  <= tgt_drive_d;
         tgt_en_q     <= tgt_en_d;
         step_q       <= step_d;
         next_q       <= next_d;
         cur_drive_q  <= cur_drive_d;
         cur_enable_q <= cur_enable_d;
         err_q        <= err_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
      end
   end

   assign cmd_ready  = aresetn && (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign cur_drive  = cur_drive_q;
   assign cur_enable = cur_enable_q;
   assign err        = err_q;

endmodule
